fifo_drain_reader: RTL

Read-side controller that sits on the read port of the team's synchronous FIFO (`fifo_dut`: registered `empty`/`full`, registered `dout`, read-over-write priority) and converts it into a valid/ready stream.
- Issues `ren` only when the registered `empty` flag is trustworthy.
- Captures `dout` one cycle after each read into a 2-entry output buffer.
- Keeps a running count of words drained.
- It is the consumer counterpart of whatever block writes the FIFO.

---
 rtl/fifo_drain_reader.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_drain_reader.sv
// rtl/fifo_drain_reader.sv - FIFO read-side controller producing a valid/ready stream
module fifo_drain_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_ren,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_ren_next;
    logic                  r_fifo_ren;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [CNT_WIDTH-1:0]  r_rd_count;
    logic                  w_push;
    logic                  w_pop;

    // CAP always returns to IDLE so the next decision sees empty after the last read
    always_comb begin
        w_state_next = r_state;
        w_ren_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && !fifo_empty && (r_occ < 2'd2)) begin
                    w_state_next = RD;
                    w_ren_next   = 1'b1;
                end
            end
            RD:      w_state_next = CAP;
            CAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fifo_ren <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fifo_ren <= w_ren_next;
        end
    end

    assign w_push = (r_state == CAP);
    assign w_pop  = (r_occ != 2'd0) && m_ready;

    // r_buf0 is the head; a simultaneous push and pop keeps occupancy and order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ      <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_rd_count <= '0;
        end else begin
            if (w_push) begin
                r_rd_count <= r_rd_count + 1'b1;
            end
            if (w_push && w_pop) begin
                if (r_occ == 2'd1) begin
                    r_buf0 <= fifo_dout;
                end else begin
                    r_buf0 <= r_buf1;
                    r_buf1 <= fifo_dout;
                end
            end else if (w_push) begin
                if (r_occ == 2'd0) begin
                    r_buf0 <= fifo_dout;
                end else begin
                    r_buf1 <= fifo_dout;
                end
                r_occ <= r_occ + 2'd1;
            end else if (w_pop) begin
                r_buf0 <= r_buf1;
                r_occ  <= r_occ - 2'd1;
            end
        end
    end

    assign fifo_ren = r_fifo_ren;
    assign m_valid  = (r_occ != 2'd0);
    assign m_data   = r_buf0;
    assign rd_count = r_rd_count;
    assign busy     = (r_state != IDLE);

endmodule
